// File: rtl/fraction_normalizer.sv
// Normalizes a 13-bit sign-magnitude fraction product into a 7-bit sign/mantissa plus left-shift count.
// Define FNORM_ROUND_EN for round-half-up; otherwise the mantissa is truncated.
module fraction_normalizer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [12:0] prod,
   output logic [6:0]  frac,
   output logic [3:0]  exp,
   output logic        zero,
   output logic        busy,
   output logic        done
);

   // start is sampled only in IDLE; busy = state != IDLE; done = state == DONE.
   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t      state, state_nxt;
   logic [11:0] mag;
   logic        sign;
   logic [3:0]  cnt;
   logic        norm;
   logic [5:0]  mant_rnd;
   logic [3:0]  exp_rnd;

   // Leading one reached, nothing to find, or the count limit hit.
   assign norm = (mag == 12'd0) || mag[11] || (cnt == 4'd11);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (norm) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         mag  <= 12'd0;
         sign <= 1'b0;
         cnt  <= 4'd0;
      end else if (state == IDLE && start) begin
         mag  <= prod[11:0];
         sign <= prod[12];
         cnt  <= 4'd0;
      end else if (state == SHIFT && !norm) begin
         mag  <= {mag[10:0], 1'b0};
         cnt  <= cnt + 4'd1;
      end
   end

`ifdef FNORM_ROUND_EN
   logic [6:0] sum;

   always_comb begin
      sum      = {1'b0, mag[11:6]} + {6'd0, mag[5]};
      mant_rnd = sum[5:0];
      exp_rnd  = cnt;
      if (sum[6]) begin
         // A carry out means the value rounded up to the next power of two.
         if (cnt != 4'd0) begin
            mant_rnd = 6'b100000;
            exp_rnd  = cnt - 4'd1;
         end else begin
            mant_rnd = 6'b111111;
            exp_rnd  = 4'd0;
         end
      end
   end
`else
   always_comb begin
      mant_rnd = mag[11:6];
      exp_rnd  = cnt;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         frac <= 7'd0;
         exp  <= 4'd0;
         zero <= 1'b0;
      end else if (state == ROUND) begin
         if (mag == 12'd0) begin
            frac <= 7'd0;
            exp  <= 4'd0;
            zero <= 1'b1;
         end else begin
            frac <= {sign, mant_rnd};
            exp  <= exp_rnd;
            zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fraction_normalizer.sv
// Directed-vector bench for fraction_normalizer; expectations follow FNORM_ROUND_EN when defined.
module tb_fraction_normalizer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [12:0] prod;
   logic [6:0]  frac;
   logic [3:0]  exp;
   logic        zero;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   fraction_normalizer dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .prod  (prod),
      .frac  (frac),
      .exp   (exp),
      .zero  (zero),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a one-cycle start; returns 1ns after the capture edge.
   task automatic start_op(input logic [12:0] p);
      prod  = p;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts edges until done is seen; lat = -1 if the budget expires.
   task automatic wait_done(input int max, output int lat);
      lat = -1;
      for (int i = 1; i <= max; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      prod  = 13'h1FFF;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || frac !== 7'd0 || exp !== 4'd0 || zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_state busy=%b done=%b frac=%b exp=%0d zero=%b required all 0", busy, done, frac, exp, zero);
      end
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_capture busy=%b required 0", busy);
      end
   endtask

   task automatic test_vector(input string name, input logic [12:0] p, input logic [6:0] ef,
                              input logic [3:0] ee, input logic ez, input int elat);
      int lat;
      start_op(p);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_capture got %b required 1", name, busy);
      end
      wait_done(20, lat);
      checks++;
      if (lat != elat) begin
         errors++;
         $display("FAIL %s latency got %0d required %0d", name, lat, elat);
      end
      checks++;
      if (frac !== ef || exp !== ee || zero !== ez) begin
         errors++;
         $display("FAIL %s result frac=%b exp=%0d zero=%b required frac=%b exp=%0d zero=%b",
                  name, frac, exp, zero, ef, ee, ez);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s done_pulse done=%b busy=%b required 0 0", name, done, busy);
      end
      checks++;
      if (frac !== ef || exp !== ee || zero !== ez) begin
         errors++;
         $display("FAIL %s hold frac=%b exp=%0d zero=%b required frac=%b exp=%0d zero=%b",
                  name, frac, exp, zero, ef, ee, ez);
      end
   endtask

   task automatic test_max_shift();
      int lat;
      int extra;
      start_op(13'b0_000000000001);
      @(posedge clk); #1;
      prod  = 13'h0FFF;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || frac !== 7'b0111111 || exp !== 4'd0) begin
         errors++;
         $display("FAIL max_shift_hold_midop busy=%b frac=%b exp=%0d required 1 0111111 0", busy, frac, exp);
      end
      wait_done(20, lat);
      checks++;
      if (lat < 0 || lat + 2 != 13) begin
         errors++;
         $display("FAIL max_shift latency got %0d required 13", (lat < 0) ? lat : lat + 2);
      end
      checks++;
      if (frac !== 7'b0100000 || exp !== 4'd11 || zero !== 1'b0) begin
         errors++;
         $display("FAIL max_shift result frac=%b exp=%0d zero=%b required 0100000 11 0", frac, exp, zero);
      end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL max_shift_no_queue active_cycles=%0d required 0", extra);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      start_op(13'b0_000000000001);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || frac !== 7'd0 || exp !== 4'd0 || zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort busy=%b done=%b frac=%b exp=%0d zero=%b required all 0", busy, done, frac, exp, zero);
      end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_abort_no_done done_cycles=%0d required 0", seen);
      end
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      prod  = 13'd0;
      test_reset();
`ifdef FNORM_ROUND_EN
      test_vector("round_basic", 13'b0_110100100011, 7'b0110101, 4'd0, 1'b0, 2);
`else
      test_vector("round_basic", 13'b0_110100100011, 7'b0110100, 4'd0, 1'b0, 2);
`endif
      test_vector("shift_six", 13'b1_000000101101, 7'b1101101, 4'd6, 1'b0, 8);
      test_vector("zero_neg", 13'b1_000000000000, 7'b0000000, 4'd0, 1'b1, 2);
`ifdef FNORM_ROUND_EN
      test_vector("carry_shifted", 13'b0_011111110000, 7'b0100000, 4'd0, 1'b0, 3);
`else
      test_vector("carry_shifted", 13'b0_011111110000, 7'b0111111, 4'd1, 1'b0, 3);
`endif
      test_vector("carry_saturate", 13'b0_111111100000, 7'b0111111, 4'd0, 1'b0, 2);
      test_max_shift();
      test_reset_abort();
`ifdef FNORM_ROUND_EN
      test_vector("after_abort", 13'b0_110100100011, 7'b0110101, 4'd0, 1'b0, 2);
`else
      test_vector("after_abort", 13'b0_110100100011, 7'b0110100, 4'd0, 1'b0, 2);
`endif
      test_vector("back_to_back", 13'b1_001000000000, 7'b1100000, 4'd2, 1'b0, 4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
